// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold, timeout-forced rotation and per-owner lock.
// Latency: grant is registered, appearing one clock after req is sampled; handover has no bubble.
// Backpressure: none; an owner keeps the grant while requesting, up to MAX_HOLD cycles unless locked.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - synchronous active-low reset
//   req      - level-sensitive request per requester
//   lock     - lock[i] suppresses the timeout while requester i owns the grant
//   grt      - one-hot grant (registered)
//   id       - {vld, index of grt} (registered), vld = |grt
//   expire   - one-cycle pulse marking a grant that was forcibly rotated
//   hold_cnt - cycles the current owner has held the grant, saturating
module rr_hold_arbiter #(
    parameter int  WIDTH    = 4,
    parameter int  MAX_HOLD = 16,
    localparam int BITW     = $clog2(WIDTH),
    localparam int BITW_H   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  req,
    input  logic [WIDTH-1:0]  lock,
    output logic [WIDTH-1:0]  grt,
    output logic [BITW:0]     id,
    output logic              expire,
    output logic [BITW_H-1:0] hold_cnt
);

    // Index width never collapses to zero, even for a single requester.
    localparam int IW = (BITW > 0) ? BITW : 1;

    // With the timeout disabled the counter simply saturates at all-ones.
    localparam logic [BITW_H-1:0] HOLD_SAT =
        (MAX_HOLD > 0) ? BITW_H'(MAX_HOLD) : {BITW_H{1'b1}};
    localparam logic [BITW_H-1:0] TO_THR =
        (MAX_HOLD > 0) ? BITW_H'(MAX_HOLD - 1) : {BITW_H{1'b1}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;

    logic [WIDTH-1:0] cand;
    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic [WIDTH-1:0] pick_oh;
    logic [IW-1:0]    pick_ptr;
    logic [BITW:0]    pick_id;
    logic             drop;
    logic             timeout;

    // ptr always holds (last owner + 1) mod WIDTH, so a single search starting
    // at ptr serves both the idle case and the handover case. While granting,
    // the owner is masked out so a timeout never re-selects it.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = (state == S_GRANT) ? (req & ~grt) : req;
        for (int i = 0; i < WIDTH; i++) begin
            if (!pick_vld && cand[(int'(ptr) + i) % WIDTH]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(ptr) + i) % WIDTH);
            end
        end
    end

    assign pick_oh  = WIDTH'(1) << pick_idx;
    assign pick_ptr = IW'((int'(pick_idx) + 1) % WIDTH);

    generate
        if (BITW > 0) begin : g_id_wide
            assign pick_id = {1'b1, pick_idx[BITW-1:0]};
        end else begin : g_id_narrow
            assign pick_id = 1'b1;
        end
    endgenerate

    // A drop takes priority over a timeout landing on the same edge.
    assign drop = (state == S_GRANT) && !req[owner];

    // ">=" rather than "==" so a counter saturated under lock or while alone
    // rotates on the first edge after lock falls or a competitor shows up.
    assign timeout = (MAX_HOLD != 0) && (state == S_GRANT) && req[owner]
                     && !lock[owner] && (hold_cnt >= TO_THR)
                     && (|(req & ~grt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            grt      <= '0;
            id       <= '0;
            expire   <= 1'b0;
            hold_cnt <= '0;
            owner    <= '0;
            ptr      <= '0;
        end else begin
            expire <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        state    <= S_GRANT;
                        grt      <= pick_oh;
                        id       <= pick_id;
                        owner    <= pick_idx;
                        ptr      <= pick_ptr;
                        hold_cnt <= '0;
                    end else begin
                        grt      <= '0;
                        id       <= '0;
                        hold_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (drop) begin
                        if (pick_vld) begin
                            grt      <= pick_oh;
                            id       <= pick_id;
                            owner    <= pick_idx;
                            ptr      <= pick_ptr;
                            hold_cnt <= '0;
                        end else begin
                            state    <= S_IDLE;
                            grt      <= '0;
                            id       <= '0;
                            hold_cnt <= '0;
                        end
                    end else if (timeout) begin
                        grt      <= pick_oh;
                        id       <= pick_id;
                        owner    <= pick_idx;
                        ptr      <= pick_ptr;
                        hold_cnt <= '0;
                        expire   <= 1'b1;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + BITW_H'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grt   <= '0;
                    id    <= '0;
                end
            endcase
        end
    end

endmodule
